// File: rtl/kianv_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package kianv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_CORE       = 0;
  localparam int unsigned ARB_AUX        = 1;
  localparam int unsigned ADDR_WIDTH_DEF = 34;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BURST_CNT_W    = 8;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational winner select: round-robin with a bounded core-priority burst.
module rr_arb_pick
  import kianv_bus_pkg::*;
#(
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic [1:0]             req,
  input  logic                   last_owner,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  output logic [1:0]             winner
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(CPU_BURST_MAX);

  logic core_may_win;

  // Under contention the core keeps winning until its burst budget is spent.
  assign core_may_win = (last_owner == 1'(ARB_AUX)) ||
                        ((last_owner == 1'(ARB_CORE)) && (burst_cnt < BURST_MAX));

  always_comb begin
    winner = 2'b00;
    if (req[ARB_CORE] && !req[ARB_AUX]) begin
      winner[ARB_CORE] = 1'b1;
    end else if (req[ARB_AUX] && !req[ARB_CORE]) begin
      winner[ARB_AUX] = 1'b1;
    end else if (req[ARB_CORE] && req[ARB_AUX]) begin
      if (core_may_win) winner[ARB_CORE] = 1'b1;
      else              winner[ARB_AUX]  = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master valid/ready arbiter in front of the memory/IO decoder; grant is
// locked per transaction and the core gets a bounded burst under contention.
module mem_bus_arbiter
  import kianv_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic [ADDR_WIDTH-1:0]   s0_addr,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic                    s0_access_fault,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic [ADDR_WIDTH-1:0]   s1_addr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic                    s1_access_fault,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_access_fault,
  output logic [1:0]              grant
);

  arb_state_t             state;
  logic                   last_owner;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [BURST_CNT_W-1:0] burst_cnt_inc;
  logic [1:0]             winner;

  rr_arb_pick #(
    .CPU_BURST_MAX(CPU_BURST_MAX)
  ) u_pick (
    .req       ({s1_valid, s0_valid}),
    .last_owner(last_owner),
    .burst_cnt (burst_cnt),
    .winner    (winner)
  );

  assign burst_cnt_inc = (burst_cnt == '1) ? burst_cnt : burst_cnt + BURST_CNT_W'(1);

  // Arbitration FSM with the burst counter and last-owner history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'(ARB_AUX);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner[ARB_CORE]) begin
            state <= GNT0;
            grant <= winner;
          end else if (winner[ARB_AUX]) begin
            state <= GNT1;
            grant <= winner;
          end
        end
        GNT0: begin
          if (m_ready) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'(ARB_CORE);
            burst_cnt  <= s1_valid ? burst_cnt_inc : '0;
          end
        end
        GNT1: begin
          if (m_ready) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'(ARB_AUX);
            burst_cnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Owner-only forwarding; the non-owner always sees an idle response.
  always_comb begin
    m_valid         = 1'b0;
    m_wstrb         = '0;
    m_addr          = '0;
    m_wdata         = '0;
    s0_ready        = 1'b0;
    s0_rdata        = '0;
    s0_access_fault = 1'b0;
    s1_ready        = 1'b0;
    s1_rdata        = '0;
    s1_access_fault = 1'b0;
    case (state)
      GNT0: begin
        m_valid         = s0_valid;
        m_wstrb         = s0_wstrb;
        m_addr          = s0_addr;
        m_wdata         = s0_wdata;
        s0_ready        = m_ready;
        s0_rdata        = m_rdata;
        s0_access_fault = m_access_fault;
      end
      GNT1: begin
        m_valid         = s1_valid;
        m_wstrb         = s1_wstrb;
        m_addr          = s1_addr;
        m_wdata         = s1_wdata;
        s1_ready        = m_ready;
        s1_rdata        = m_rdata;
        s1_access_fault = m_access_fault;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// model of who should own the bus next.
module tb_mem_bus_arbiter;

  localparam int unsigned AW    = 34;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned BURST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [SW-1:0] s0_wstrb = '0, s1_wstrb = '0;
  logic [AW-1:0] s0_addr = '0, s1_addr = '0;
  logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic          s0_access_fault, s1_access_fault;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [SW-1:0] m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_access_fault = 1'b0;
  logic [1:0]    grant;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 1;   // 0 = core, 1 = aux
  int m_streak = 0;   // core wins in a row while aux was waiting
  int last_own = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_BURST_MAX(BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_wstrb(s0_wstrb), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_rdata(s0_rdata), .s0_access_fault(s0_access_fault),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_wstrb(s1_wstrb), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_rdata(s1_rdata), .s1_access_fault(s1_access_fault),
    .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_access_fault(m_access_fault),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core may win at most BURST times in a row while aux is kept waiting.
  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (m_last == 0 && m_streak >= int'(BURST)) return 1;
    return 0;
  endfunction

  function automatic void model_complete(input int own, input bit aux_waiting);
    if (own == 0) m_streak = aux_waiting ? ((m_streak < 255) ? m_streak + 1 : 255) : 0;
    else          m_streak = 0;
    m_last = own;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_s0_ready"}, 64'(s0_ready), 64'(0));
    chk({tag, "_s1_ready"}, 64'(s1_ready), 64'(0));
    chk({tag, "_s0_rdata"}, 64'(s0_rdata), 64'(0));
    chk({tag, "_s1_rdata"}, 64'(s1_rdata), 64'(0));
    chk({tag, "_s0_fault"}, 64'(s0_access_fault), 64'(0));
    chk({tag, "_s1_fault"}, 64'(s1_access_fault), 64'(0));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0; m_access_fault = 1'b0;
    @(negedge clk);
    reset = 1'b0; m_ready = 1'b1; m_rdata = 32'hA5A5_5A5A; m_access_fault = 1'b1;
    #1;
    check_quiet("reset");
    m_ready = 1'b0; m_access_fault = 1'b0;
    m_last = 1; m_streak = 0;
  endtask

  // One IDLE cycle with no requests; optionally a stray m_ready pulse.
  task automatic idle_cycle(input bit stray_ready);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    m_ready = stray_ready; m_rdata = $urandom; m_access_fault = stray_ready;
    #1;
    check_quiet("idle");
  endtask

  // Arbitration cycle plus a full granted transaction of lat+1 cycles.
  task automatic txn(input bit r0, input bit r1, input int lat, input int drop_at,
                     input logic [DW-1:0] fin_rdata, input bit fin_fault);
    int own;
    bit ev, last_cyc;
    logic [1:0] exp_g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, er;
    logic [SW-1:0] es;
    logic o_rdy, o_flt, n_rdy, n_flt;
    logic [DW-1:0] o_rd, n_rd;
    @(negedge clk);
    s0_valid = r0; s1_valid = r1;
    m_ready = 1'b0; m_access_fault = 1'b0; m_rdata = $urandom;
    #1;
    chk("arb_m_valid", 64'(m_valid), 64'(0));
    chk("arb_grant", 64'(grant), 64'(0));
    own = model_pick(r0, r1);
    last_own = own;
    exp_g = (own == 0) ? 2'b01 : 2'b10;
    ea = (own == 0) ? s0_addr  : s1_addr;
    ew = (own == 0) ? s0_wdata : s1_wdata;
    es = (own == 0) ? s0_wstrb : s1_wstrb;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      last_cyc = (k == lat);
      ev = !(drop_at >= 0 && k >= drop_at);
      if (own == 0) s0_valid = ev; else s1_valid = ev;
      er = last_cyc ? fin_rdata : DW'($urandom);
      m_ready = last_cyc; m_rdata = er; m_access_fault = last_cyc && fin_fault;
      #1;
      o_rdy = (own == 0) ? s0_ready : s1_ready;
      o_rd  = (own == 0) ? s0_rdata : s1_rdata;
      o_flt = (own == 0) ? s0_access_fault : s1_access_fault;
      n_rdy = (own == 0) ? s1_ready : s0_ready;
      n_rd  = (own == 0) ? s1_rdata : s0_rdata;
      n_flt = (own == 0) ? s1_access_fault : s0_access_fault;
      chk("grant", 64'(grant), 64'(exp_g));
      chk("m_valid", 64'(m_valid), 64'(ev));
      chk("m_addr", 64'(m_addr), 64'(ea));
      chk("m_wdata", 64'(m_wdata), 64'(ew));
      chk("m_wstrb", 64'(m_wstrb), 64'(es));
      chk("owner_ready", 64'(o_rdy), 64'(last_cyc));
      chk("owner_rdata", 64'(o_rd), 64'(er));
      chk("owner_fault", 64'(o_flt), 64'(last_cyc && fin_fault));
      chk("other_ready", 64'(n_rdy), 64'(0));
      chk("other_rdata", 64'(n_rd), 64'(0));
      chk("other_fault", 64'(n_flt), 64'(0));
    end
    model_complete(own, (own == 0) ? r1 : 1'b0);
    @(posedge clk);
    #1;
    if (own == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
    m_ready = 1'b0; m_access_fault = 1'b0;
  endtask

  task automatic rand_payload();
    s0_addr  = AW'({$urandom, $urandom});
    s1_addr  = AW'({$urandom, $urandom});
    s0_wdata = $urandom; s1_wdata = $urandom;
    s0_wstrb = SW'($urandom); s1_wstrb = SW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit r0, r1;
    reset_dut();

    // Single core read with 3 wait cycles.
    s0_addr = 34'h0_8000_0000; s0_wstrb = 4'h0; s0_wdata = 32'h0;
    txn(1'b1, 1'b0, 3, -1, 32'hDEADBEEF, 1'b0);
    idle_cycle(1'b0);

    // Simultaneous requests straight after reset.
    reset_dut();
    rand_payload();
    txn(1'b1, 1'b1, 1, -1, $urandom, 1'b0);
    chk("simul_first_owner", 64'(last_own), 64'(0));
    txn(1'b0, 1'b1, 1, -1, $urandom, 1'b0);
    chk("simul_second_owner", 64'(last_own), 64'(1));
    idle_cycle(1'b0);

    // Starvation bound: four core wins, then one aux win, repeating.
    for (int i = 0; i < 15; i++) begin
      rand_payload();
      txn(1'b1, 1'b1, int'($urandom_range(0, 2)), -1, $urandom, 1'b0);
      chk("starve_owner", 64'(last_own), 64'((i % 5 == 4) ? 1 : 0));
    end
    idle_cycle(1'b0);

    // Aux write that faults.
    s1_wstrb = 4'hF; s1_addr = 34'h2_0000_0010; s1_wdata = 32'h1234_5678;
    txn(1'b0, 1'b1, 2, -1, $urandom, 1'b1);
    idle_cycle(1'b0);

    // Exhaust the core burst, then reset in the middle of a core grant.
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      txn(1'b1, 1'b1, 0, -1, $urandom, 1'b0);
      chk("preburst_owner", 64'(last_own), 64'(0));
    end
    @(negedge clk);
    s0_valid = 1'b1; s1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_txn_grant", 64'(grant), 64'(1));
    chk("rst_txn_m_valid", 64'(m_valid), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_txn_no_ready", 64'(s0_ready), 64'(0));
    @(negedge clk);
    reset = 1'b0; s0_valid = 1'b0;
    #1;
    check_quiet("post_reset");
    m_last = 1; m_streak = 0;
    rand_payload();
    txn(1'b1, 1'b1, 1, -1, $urandom, 1'b0);
    chk("post_reset_owner", 64'(last_own), 64'(0));

    // Owner drops valid early; grant must stay locked until m_ready.
    rand_payload();
    txn(1'b1, 1'b1, 4, 1, $urandom, 1'b0);
    chk("drop_owner", 64'(last_own), 64'(0));
    txn(1'b0, 1'b1, 1, -1, $urandom, 1'b0);
    chk("drop_next_owner", 64'(last_own), 64'(1));

    // Stray m_ready while idle is ignored.
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      rand_payload();
      txn(r0, r1, int'($urandom_range(0, 3)), -1, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the physical memory bus between the RV32IMA core's MMU-side port and a secondary bus master, such as a DMA engine or framebuffer fetcher. It sits between those masters and the memory/IO decoder. It uses the same valid/ready handshake and 34-bit physical address width as the core. Arbitration is round-robin, with a bounded core-priority burst and the grant locked for each whole transaction.

## Interface
Parameters:
- ADDR_WIDTH, 34, physical address width
- DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8
- CPU_BURST_MAX, 4, max consecutive core grants while master 1 is waiting; range 1..255

Ports (clk and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- s0_valid  in  1  core request; held until s0_ready
- s0_ready  out  1  core transaction complete (one-cycle pulse)
- s0_wstrb  in  4  core write strobes; 0 = read
- s0_addr  in  ADDR_WIDTH  core physical address
- s0_wdata  in  DATA_WIDTH  core write data
- s0_rdata  out  DATA_WIDTH  core read data
- s0_access_fault  out  1  fault for the core's transaction
- s1_valid / s1_ready / s1_wstrb / s1_addr / s1_wdata / s1_rdata / s1_access_fault  same widths and meaning, master 1
- m_valid  out  1  request to memory
- m_ready  in  1  memory transaction complete
- m_wstrb  out  4  forwarded strobes
- m_addr  out  ADDR_WIDTH  forwarded address
- m_wdata  out  DATA_WIDTH  forwarded write data
- m_rdata  in  DATA_WIDTH  memory read data
- m_access_fault  in  1  memory fault, valid with m_ready
- grant  out  2  one-hot current owner; 2'b00 when idle

## Operation
- FSM states: IDLE, GNT0, GNT1.
- IDLE: pick a winner from the sampled s0_valid/s1_valid and register the grant. Nothing is forwarded in IDLE.
  - Only one master valid: grant it.
  - Both valid:
    - If burst_cnt < CPU_BURST_MAX and the last owner was 0 → grant 0.
    - Else if the last owner was 1 → grant 0.
    - Else → grant 1.
  - The core therefore gets at most CPU_BURST_MAX back-to-back grants while master 1 waits. After a master-1 grant, the core wins the next contended arbitration.
- GNTx: forward the owner's s*_valid/wstrb/addr/wdata to m_* combinationally.
  - s{x}_ready = m_ready; s{x}_rdata = m_rdata; s{x}_access_fault = m_access_fault.
  - The non-owner sees ready=0, access_fault=0, rdata=0.
- GNTx → IDLE on the cycle m_ready=1. last_owner ← x.
- burst_cnt (8 bit):
  - Increments on completion of a core grant while s1_valid=1, saturating at 255.
  - Clears on completion of a master-1 grant, or when a core grant completes with s1_valid=0.
- The grant is locked for the whole transaction. If the owner drops valid early (a protocol violation), the FSM stays in GNTx until m_ready, with m_valid following the owner's valid. No abort.
- m_valid=0 whenever the state is not GNTx. Non-owner signals are never forwarded.

## Timing
- Reset values: state=IDLE, grant=00, last_owner=1 (the core wins the first contention), burst_cnt=0, m_valid=0, all s*_ready=0, all s*_access_fault=0, all rdata=0.
- Request to m_valid latency is 1 cycle: valid sampled in IDLE at edge N, m_valid high during cycle N+1.
- m_ready to s_ready: 0 cycles, combinational.
- Minimum of 1 idle cycle (m_valid=0) between consecutive transactions. Single-master back-to-back throughput is therefore one transaction per (memory latency + 2) cycles.
- Reset asserted mid-transaction: state → IDLE at the next edge and m_valid drops. The in-flight memory response is discarded and no s*_ready is generated.
- m_ready arriving in IDLE is ignored.
- m_ready and a new request in the same cycle: the completion takes effect at that edge. Re-arbitration occurs in the following IDLE cycle.

## Structure
- The shared package `kianv_bus_pkg` holds:
  - `arb_state_t` (IDLE, GNT0, GNT1)
  - the `ARB_CORE` / `ARB_AUX` index constants
  - the default ADDR/DATA width localparams
- One sub-module, `rr_arb_pick`: a combinational winner select with inputs (req[1:0], last_owner, burst_cnt, CPU_BURST_MAX) and a one-hot winner output.
- The top level holds the FSM, the counters and the forwarding muxes.

## Test plan
- Single core read:
  - Stimulus: s0_valid with addr 0x0_8000_0000, memory ready after 3 cycles with rdata 0xDEADBEEF.
  - Required: m_valid high 1 cycle after request; s0_ready pulses with s0_rdata=0xDEADBEEF; grant back to 00 next cycle; s1_ready stays 0.
- Simultaneous requests after reset:
  - Stimulus: s0_valid and s1_valid asserted together.
  - Required: core granted first, then master 1; grant sequence 01, 00, 10, 00.
- Starvation bound:
  - Stimulus: CPU_BURST_MAX=4; core re-requests continuously while s1_valid is held high.
  - Required: exactly 4 core completions, then one master-1 grant, then the pattern repeats; burst_cnt clears after each master-1 grant.
- Fault routing:
  - Stimulus: master 1 write (wstrb 4'hF); memory returns m_ready together with m_access_fault=1.
  - Required: s1_access_fault=1 in that cycle; s0_access_fault=0.
- Reset mid-transaction:
  - Stimulus: assert reset while in GNT0 before m_ready.
  - Required: m_valid=0 and grant=00 at the next edge; no s0_ready; the core wins the next contention.
- Early valid drop:
  - Stimulus: owner deasserts valid before m_ready.
  - Required: the FSM stays in GNTx until m_ready; the other master is not granted in between.
